// File: rtl/zap_memory_main.sv
// ----------------------------------------------------------------------------
// zap_memory_main
//   Memory stage of the ZAP pipeline. It sits between the ALU stage and
//   writeback. For condition-passed loads and stores it issues one data-bus
//   access and stalls the pipe until the bus acknowledges. It then aligns and
//   extends load data and forwards the instruction to writeback. Any other
//   instruction passes through in a single cycle.
//
//   Ports
//     i_clk, i_reset            clock; synchronous active-high reset
//     i_clear_from_writeback    pipeline flush
//     i_*_ff                    registered ALU-stage instruction fields
//     i_data_ack/rdata/abort    data-bus response
//     o_data_*                  data-bus request (all registered except stall)
//     o_data_stall              stall to the ALU stage and upstream
//     o_*_ff                    registered instruction fields to writeback
//
//   state | meaning
//   ------+------------------------------------------------------------------
//   IDLE  | no bus cycle open; accept a new instruction each clock
//   BUSY  | bus request outstanding; pipe stalled until i_data_ack
// ----------------------------------------------------------------------------
module zap_memory_main #(
  parameter int PHY_REGS = 46
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_clear_from_writeback,
  input  logic                        i_dav_ff,
  input  logic [31:0]                 i_alu_result_ff,
  input  logic [31:0]                 i_mem_address_ff,
  input  logic [31:0]                 i_mem_srcdest_value_ff,
  input  logic [31:0]                 i_pc_plus_8_ff,
  input  logic [$clog2(PHY_REGS)-1:0] i_destination_index_ff,
  input  logic [$clog2(PHY_REGS)-1:0] i_mem_srcdest_index_ff,
  input  logic                        i_mem_load_ff,
  input  logic                        i_mem_store_ff,
  input  logic                        i_mem_unsigned_byte_enable_ff,
  input  logic                        i_mem_signed_byte_enable_ff,
  input  logic                        i_mem_unsigned_halfword_enable_ff,
  input  logic                        i_mem_signed_halfword_enable_ff,
  input  logic                        i_mem_translate_ff,
  input  logic                        i_abt_ff,
  input  logic                        i_irq_ff,
  input  logic                        i_fiq_ff,
  input  logic                        i_swi_ff,
  input  logic                        i_data_ack,
  input  logic [31:0]                 i_data_rdata,
  input  logic                        i_data_abort,
  output logic                        o_data_stb,
  output logic                        o_data_wen,
  output logic [31:0]                 o_data_addr,
  output logic [31:0]                 o_data_wdata,
  output logic [3:0]                  o_data_ben,
  output logic                        o_data_translate,
  output logic                        o_data_stall,
  output logic                        o_dav_ff,
  output logic [31:0]                 o_alu_result_ff,
  output logic [31:0]                 o_pc_plus_8_ff,
  output logic [$clog2(PHY_REGS)-1:0] o_destination_index_ff,
  output logic [$clog2(PHY_REGS)-1:0] o_mem_srcdest_index_ff,
  output logic                        o_mem_load_ff,
  output logic                        o_abt_ff,
  output logic                        o_irq_ff,
  output logic                        o_fiq_ff,
  output logic                        o_swi_ff,
  output logic [31:0]                 o_mem_load_data_ff,
  output logic                        o_dabt_ff
);

  localparam int IW = $clog2(PHY_REGS);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t state;
  logic   kill;

  // Instruction parked for the duration of the bus cycle.
  logic [31:0]   p_alu_result;
  logic [31:0]   p_pc_plus_8;
  logic [IW-1:0] p_destination_index;
  logic [IW-1:0] p_srcdest_index;
  logic          p_load;
  logic          p_abt;
  logic          p_irq;
  logic          p_fiq;
  logic          p_swi;
  logic          p_byte;
  logic          p_half;
  logic          p_signed;
  logic [1:0]    p_addr_lo;

  logic          mem_instr;
  logic          is_byte;
  logic          is_half;
  logic          is_signed;
  logic [3:0]    ben_next;
  logic [31:0]   wdata_next;
  logic [31:0]   rot;
  logic [15:0]   half;
  logic [31:0]   load_aligned;
  logic          squash;

  assign mem_instr    = i_dav_ff & (i_mem_load_ff | i_mem_store_ff);
  assign is_byte      = i_mem_unsigned_byte_enable_ff | i_mem_signed_byte_enable_ff;
  assign is_half      = i_mem_unsigned_halfword_enable_ff | i_mem_signed_halfword_enable_ff;
  assign is_signed    = is_byte ? i_mem_signed_byte_enable_ff : i_mem_signed_halfword_enable_ff;
  assign o_data_stall = (state == BUSY);
  // A flush arriving in the ack cycle itself must also squash the result.
  assign squash       = kill | i_clear_from_writeback;

  // Byte enables and lane-replicated write data for the access being issued.
  always_comb begin
    ben_next   = 4'b1111;
    wdata_next = i_mem_srcdest_value_ff;
    if (is_byte) begin
      ben_next   = 4'b0001 << i_mem_address_ff[1:0];
      wdata_next = {4{i_mem_srcdest_value_ff[7:0]}};
    end else if (is_half) begin
      ben_next   = i_mem_address_ff[1] ? 4'b1100 : 4'b0011;
      wdata_next = {2{i_mem_srcdest_value_ff[15:0]}};
    end
  end

  // Load alignment. The rotation puts the addressed byte in lane 0, which
  // serves both rotated word loads and byte extraction.
  always_comb begin
    rot = i_data_rdata;
    case (p_addr_lo)
      2'd1:    rot = {i_data_rdata[7:0],  i_data_rdata[31:8]};
      2'd2:    rot = {i_data_rdata[15:0], i_data_rdata[31:16]};
      2'd3:    rot = {i_data_rdata[23:0], i_data_rdata[31:24]};
      default: rot = i_data_rdata;
    endcase
    half         = p_addr_lo[1] ? i_data_rdata[31:16] : i_data_rdata[15:0];
    load_aligned = rot;
    if (p_byte) begin
      load_aligned = p_signed ? {{24{rot[7]}}, rot[7:0]} : {24'd0, rot[7:0]};
    end else if (p_half) begin
      load_aligned = p_signed ? {{16{half[15]}}, half} : {16'd0, half};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || (state == IDLE && i_clear_from_writeback)) begin
      state                  <= IDLE;
      kill                   <= 1'b0;
      o_data_stb             <= 1'b0;
      o_data_wen             <= 1'b0;
      o_data_addr            <= 32'd0;
      o_data_wdata           <= 32'd0;
      o_data_ben             <= 4'd0;
      o_data_translate       <= 1'b0;
      o_dav_ff               <= 1'b0;
      o_alu_result_ff        <= 32'd0;
      o_pc_plus_8_ff         <= 32'd0;
      o_destination_index_ff <= '0;
      o_mem_srcdest_index_ff <= '0;
      o_mem_load_ff          <= 1'b0;
      o_abt_ff               <= 1'b0;
      o_irq_ff               <= 1'b0;
      o_fiq_ff               <= 1'b0;
      o_swi_ff               <= 1'b0;
      o_mem_load_data_ff     <= 32'd0;
      o_dabt_ff              <= 1'b0;
      p_alu_result           <= 32'd0;
      p_pc_plus_8            <= 32'd0;
      p_destination_index    <= '0;
      p_srcdest_index        <= '0;
      p_load                 <= 1'b0;
      p_abt                  <= 1'b0;
      p_irq                  <= 1'b0;
      p_fiq                  <= 1'b0;
      p_swi                  <= 1'b0;
      p_byte                 <= 1'b0;
      p_half                 <= 1'b0;
      p_signed               <= 1'b0;
      p_addr_lo              <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          kill             <= 1'b0;
          o_data_translate <= i_mem_translate_ff;
          if (mem_instr) begin
            state               <= BUSY;
            o_data_stb          <= 1'b1;
            // Load wins when both access types are flagged.
            o_data_wen          <= i_mem_store_ff & ~i_mem_load_ff;
            o_data_addr         <= {i_mem_address_ff[31:2], 2'b00};
            o_data_wdata        <= wdata_next;
            o_data_ben          <= ben_next;
            p_alu_result        <= i_alu_result_ff;
            p_pc_plus_8         <= i_pc_plus_8_ff;
            p_destination_index <= i_destination_index_ff;
            p_srcdest_index     <= i_mem_srcdest_index_ff;
            p_load              <= i_mem_load_ff;
            p_abt               <= i_abt_ff;
            p_irq               <= i_irq_ff;
            p_fiq               <= i_fiq_ff;
            p_swi               <= i_swi_ff;
            p_byte              <= is_byte;
            p_half              <= is_half;
            p_signed            <= is_signed;
            p_addr_lo           <= i_mem_address_ff[1:0];
            o_dav_ff            <= 1'b0;
            o_mem_load_ff       <= 1'b0;
            o_mem_load_data_ff  <= 32'd0;
            o_dabt_ff           <= 1'b0;
          end else begin
            o_data_stb             <= 1'b0;
            o_data_wen             <= 1'b0;
            o_data_ben             <= 4'd0;
            o_dav_ff               <= i_dav_ff;
            o_alu_result_ff        <= i_alu_result_ff;
            o_pc_plus_8_ff         <= i_pc_plus_8_ff;
            o_destination_index_ff <= i_destination_index_ff;
            o_mem_srcdest_index_ff <= i_mem_srcdest_index_ff;
            o_abt_ff               <= i_abt_ff;
            o_irq_ff               <= i_irq_ff;
            o_fiq_ff               <= i_fiq_ff;
            o_swi_ff               <= i_swi_ff;
            o_mem_load_ff          <= 1'b0;
            o_mem_load_data_ff     <= 32'd0;
            o_dabt_ff              <= 1'b0;
          end
        end

        BUSY: begin
          if (i_data_ack) begin
            state                  <= IDLE;
            kill                   <= 1'b0;
            o_data_stb             <= 1'b0;
            o_dav_ff               <= ~squash;
            o_alu_result_ff        <= p_alu_result;
            o_pc_plus_8_ff         <= p_pc_plus_8;
            o_destination_index_ff <= p_destination_index;
            o_mem_srcdest_index_ff <= p_srcdest_index;
            o_mem_load_ff          <= p_load;
            o_abt_ff               <= p_abt;
            o_irq_ff               <= p_irq;
            o_fiq_ff               <= p_fiq;
            o_swi_ff               <= p_swi;
            o_mem_load_data_ff     <= (p_load & ~i_data_abort) ? load_aligned : 32'd0;
            o_dabt_ff              <= i_data_abort & ~squash;
          end else begin
            // The bus cycle is never abandoned; a flush only marks it dead.
            if (i_clear_from_writeback) kill <= 1'b1;
            o_dav_ff <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zap_memory_main.sv
module tb_zap_memory_main;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_clear_from_writeback;
  logic        i_dav_ff;
  logic [31:0] i_alu_result_ff;
  logic [31:0] i_mem_address_ff;
  logic [31:0] i_mem_srcdest_value_ff;
  logic [31:0] i_pc_plus_8_ff;
  logic [5:0]  i_destination_index_ff;
  logic [5:0]  i_mem_srcdest_index_ff;
  logic        i_mem_load_ff;
  logic        i_mem_store_ff;
  logic        i_mem_unsigned_byte_enable_ff;
  logic        i_mem_signed_byte_enable_ff;
  logic        i_mem_unsigned_halfword_enable_ff;
  logic        i_mem_signed_halfword_enable_ff;
  logic        i_mem_translate_ff;
  logic        i_abt_ff;
  logic        i_irq_ff;
  logic        i_fiq_ff;
  logic        i_swi_ff;
  logic        i_data_ack;
  logic [31:0] i_data_rdata;
  logic        i_data_abort;
  logic        o_data_stb;
  logic        o_data_wen;
  logic [31:0] o_data_addr;
  logic [31:0] o_data_wdata;
  logic [3:0]  o_data_ben;
  logic        o_data_translate;
  logic        o_data_stall;
  logic        o_dav_ff;
  logic [31:0] o_alu_result_ff;
  logic [31:0] o_pc_plus_8_ff;
  logic [5:0]  o_destination_index_ff;
  logic [5:0]  o_mem_srcdest_index_ff;
  logic        o_mem_load_ff;
  logic        o_abt_ff;
  logic        o_irq_ff;
  logic        o_fiq_ff;
  logic        o_swi_ff;
  logic [31:0] o_mem_load_data_ff;
  logic        o_dabt_ff;

  int checks = 0;
  int errors = 0;
  int n_stall, n_stb, n_dav, total_dav;

  zap_memory_main #(.PHY_REGS(46)) dut (
    .i_clk                             (i_clk),
    .i_reset                           (i_reset),
    .i_clear_from_writeback            (i_clear_from_writeback),
    .i_dav_ff                          (i_dav_ff),
    .i_alu_result_ff                   (i_alu_result_ff),
    .i_mem_address_ff                  (i_mem_address_ff),
    .i_mem_srcdest_value_ff            (i_mem_srcdest_value_ff),
    .i_pc_plus_8_ff                    (i_pc_plus_8_ff),
    .i_destination_index_ff            (i_destination_index_ff),
    .i_mem_srcdest_index_ff            (i_mem_srcdest_index_ff),
    .i_mem_load_ff                     (i_mem_load_ff),
    .i_mem_store_ff                    (i_mem_store_ff),
    .i_mem_unsigned_byte_enable_ff     (i_mem_unsigned_byte_enable_ff),
    .i_mem_signed_byte_enable_ff       (i_mem_signed_byte_enable_ff),
    .i_mem_unsigned_halfword_enable_ff (i_mem_unsigned_halfword_enable_ff),
    .i_mem_signed_halfword_enable_ff   (i_mem_signed_halfword_enable_ff),
    .i_mem_translate_ff                (i_mem_translate_ff),
    .i_abt_ff                          (i_abt_ff),
    .i_irq_ff                          (i_irq_ff),
    .i_fiq_ff                          (i_fiq_ff),
    .i_swi_ff                          (i_swi_ff),
    .i_data_ack                        (i_data_ack),
    .i_data_rdata                      (i_data_rdata),
    .i_data_abort                      (i_data_abort),
    .o_data_stb                        (o_data_stb),
    .o_data_wen                        (o_data_wen),
    .o_data_addr                       (o_data_addr),
    .o_data_wdata                      (o_data_wdata),
    .o_data_ben                        (o_data_ben),
    .o_data_translate                  (o_data_translate),
    .o_data_stall                      (o_data_stall),
    .o_dav_ff                          (o_dav_ff),
    .o_alu_result_ff                   (o_alu_result_ff),
    .o_pc_plus_8_ff                    (o_pc_plus_8_ff),
    .o_destination_index_ff            (o_destination_index_ff),
    .o_mem_srcdest_index_ff            (o_mem_srcdest_index_ff),
    .o_mem_load_ff                     (o_mem_load_ff),
    .o_abt_ff                          (o_abt_ff),
    .o_irq_ff                          (o_irq_ff),
    .o_fiq_ff                          (o_fiq_ff),
    .o_swi_ff                          (o_swi_ff),
    .o_mem_load_data_ff                (o_mem_load_data_ff),
    .o_dabt_ff                         (o_dabt_ff)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_nop();
    i_dav_ff                          = 1'b0;
    i_alu_result_ff                   = 32'd0;
    i_mem_address_ff                  = 32'd0;
    i_mem_srcdest_value_ff            = 32'd0;
    i_pc_plus_8_ff                    = 32'd0;
    i_destination_index_ff            = 6'd0;
    i_mem_srcdest_index_ff            = 6'd0;
    i_mem_load_ff                     = 1'b0;
    i_mem_store_ff                    = 1'b0;
    i_mem_unsigned_byte_enable_ff     = 1'b0;
    i_mem_signed_byte_enable_ff       = 1'b0;
    i_mem_unsigned_halfword_enable_ff = 1'b0;
    i_mem_signed_halfword_enable_ff   = 1'b0;
    i_mem_translate_ff                = 1'b0;
    i_abt_ff                          = 1'b0;
    i_irq_ff                          = 1'b0;
    i_fiq_ff                          = 1'b0;
    i_swi_ff                          = 1'b0;
  endtask

  task automatic drive_add(input logic [31:0] res, input logic [5:0] dst);
    drive_nop();
    i_dav_ff               = 1'b1;
    i_alu_result_ff        = res;
    i_destination_index_ff = dst;
    i_pc_plus_8_ff         = 32'h0000_2008;
  endtask

  // Present a memory instruction for one edge, then fall back to a bubble.
  task automatic issue_mem(input logic ld, input logic st, input logic ub, input logic sb,
                           input logic uh, input logic sh, input logic [31:0] addr,
                           input logic [31:0] val, input logic [5:0] sd);
    drive_nop();
    i_dav_ff                          = 1'b1;
    i_mem_load_ff                     = ld;
    i_mem_store_ff                    = st;
    i_mem_unsigned_byte_enable_ff     = ub;
    i_mem_signed_byte_enable_ff       = sb;
    i_mem_unsigned_halfword_enable_ff = uh;
    i_mem_signed_halfword_enable_ff   = sh;
    i_mem_address_ff                  = addr;
    i_alu_result_ff                   = addr;
    i_mem_srcdest_value_ff            = val;
    i_mem_srcdest_index_ff            = sd;
    i_pc_plus_8_ff                    = 32'h0000_1008;
    tick();
    drive_nop();
  endtask

  // Run lat BUSY cycles with the ack in the last one; optionally flush in cycle clr_at.
  task automatic busy(input int lat, input logic [31:0] rd, input logic ab, input int clr_at);
    n_stall = 0;
    n_stb   = 0;
    n_dav   = 0;
    for (int c = 1; c <= lat; c++) begin
      if (o_data_stall) n_stall++;
      if (o_data_stb)   n_stb++;
      if (o_dav_ff)     n_dav++;
      if (c == clr_at) i_clear_from_writeback = 1'b1;
      if (c == lat) begin
        i_data_ack   = 1'b1;
        i_data_rdata = rd;
        i_data_abort = ab;
      end
      tick();
      i_data_ack             = 1'b0;
      i_data_abort           = 1'b0;
      i_data_rdata           = 32'd0;
      i_clear_from_writeback = 1'b0;
    end
  endtask

  task automatic load_test(input string tag, input logic ub, input logic sb, input logic uh,
                           input logic sh, input logic [31:0] addr, input logic [31:0] rd,
                           input logic [31:0] exp);
    issue_mem(1'b1, 1'b0, ub, sb, uh, sh, addr, 32'd0, 6'd9);
    busy(1, rd, 1'b0, 0);
    chk({tag, "_data"}, o_mem_load_data_ff, exp);
    chk({tag, "_dav"}, {31'd0, o_dav_ff}, 32'd1);
  endtask

  initial begin
    drive_nop();
    i_reset                = 1'b1;
    i_clear_from_writeback = 1'b0;
    i_data_ack             = 1'b0;
    i_data_rdata           = 32'd0;
    i_data_abort           = 1'b0;
    tick();
    tick();
    chk("rst_stb",   {31'd0, o_data_stb},   32'd0);
    chk("rst_stall", {31'd0, o_data_stall}, 32'd0);
    chk("rst_dav",   {31'd0, o_dav_ff},     32'd0);
    chk("rst_addr",  o_data_addr,           32'd0);
    chk("rst_ldata", o_mem_load_data_ff,    32'd0);
    i_reset = 1'b0;

    // Word store, ack in the third BUSY cycle.
    issue_mem(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h1122_3344, 6'd4);
    chk("st_stb",   {31'd0, o_data_stb}, 32'd1);
    chk("st_wen",   {31'd0, o_data_wen}, 32'd1);
    chk("st_ben",   {28'd0, o_data_ben}, 32'hF);
    chk("st_addr",  o_data_addr,         32'h100);
    chk("st_wdata", o_data_wdata,        32'h1122_3344);
    busy(3, 32'd0, 1'b0, 0);
    total_dav = n_dav;
    chk("st_stall_cycles", n_stall, 32'd3);
    chk("st_dav_done",     {31'd0, o_dav_ff},     32'd1);
    chk("st_stall_done",   {31'd0, o_data_stall}, 32'd0);
    chk("st_ldata",        o_mem_load_data_ff,    32'd0);
    if (o_dav_ff) total_dav++;
    tick();
    if (o_dav_ff) total_dav++;
    chk("st_dav_pulses", total_dav, 32'd1);

    // Load alignment and extension.
    load_test("ldrsb", 1'b0, 1'b1, 1'b0, 1'b0, 32'h203, 32'h80FF_FF7F, 32'hFFFF_FF80);
    chk("ldrsb_wen",  {31'd0, o_data_wen},    32'd0);
    chk("ldrsb_load", {31'd0, o_mem_load_ff}, 32'd1);
    chk("ldrsb_sd",   {26'd0, o_mem_srcdest_index_ff}, 32'd9);
    load_test("ldrb",  1'b1, 1'b0, 1'b0, 1'b0, 32'h203, 32'h80FF_FF7F, 32'h0000_0080);
    load_test("ldrh",  1'b0, 1'b0, 1'b1, 1'b0, 32'h202, 32'h8001_0000, 32'h0000_8001);
    load_test("ldrsh", 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 32'h0000_8001, 32'hFFFF_8001);
    load_test("ldr",   1'b0, 1'b0, 1'b0, 1'b0, 32'h101, 32'hAABB_CCDD, 32'hDDAA_BBCC);
    chk("ldr_addr", o_data_addr, 32'h100);

    // Byte and halfword stores.
    issue_mem(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h102, 32'h0000_005A, 6'd2);
    chk("stb_ben",   {28'd0, o_data_ben}, 32'h4);
    chk("stb_wdata", o_data_wdata,        32'h5A5A_5A5A);
    busy(1, 32'd0, 1'b0, 0);
    issue_mem(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h102, 32'hFFFF_1234, 6'd2);
    chk("sth_ben",   {28'd0, o_data_ben}, 32'hC);
    chk("sth_wdata", o_data_wdata,        32'h1234_1234);
    busy(1, 32'd0, 1'b0, 0);

    // Load and store both flagged: load wins.
    issue_mem(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h300, 32'h1, 6'd3);
    chk("ldst_wen", {31'd0, o_data_wen}, 32'd0);
    busy(1, 32'h0BAD_F00D, 1'b0, 0);
    chk("ldst_data", o_mem_load_data_ff, 32'h0BAD_F00D);

    // Aborted load, then an ADD passes in one cycle.
    issue_mem(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h400, 32'd0, 6'd5);
    busy(2, 32'hFFFF_FFFF, 1'b1, 0);
    chk("abt_dabt", {31'd0, o_dabt_ff},  32'd1);
    chk("abt_data", o_mem_load_data_ff,  32'd0);
    drive_add(32'h77, 6'd5);
    tick();
    chk("abt_add_dav",  {31'd0, o_dav_ff},     32'd1);
    chk("abt_add_res",  o_alu_result_ff,       32'h77);
    chk("abt_add_dabt", {31'd0, o_dabt_ff},    32'd0);
    chk("abt_add_load", {31'd0, o_mem_load_ff}, 32'd0);

    // dav = 0 passes through as a bubble.
    drive_nop();
    i_alu_result_ff = 32'h55;
    tick();
    chk("nodav_dav", {31'd0, o_dav_ff}, 32'd0);
    chk("nodav_res", o_alu_result_ff,   32'h55);

    // Flush in IDLE wipes the outputs and issues nothing.
    issue_mem(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h500, 32'd0, 6'd1);
    busy(1, 32'd0, 1'b0, 0);
    drive_add(32'h88, 6'd6);
    i_clear_from_writeback = 1'b1;
    i_mem_load_ff = 1'b1;
    tick();
    i_clear_from_writeback = 1'b0;
    drive_nop();
    chk("clr_idle_dav", {31'd0, o_dav_ff},   32'd0);
    chk("clr_idle_res", o_alu_result_ff,     32'd0);
    chk("clr_idle_stb", {31'd0, o_data_stb}, 32'd0);

    // Flush mid-BUSY: bus cycle completes, result squashed, abort suppressed.
    issue_mem(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h600, 32'd0, 6'd7);
    busy(3, 32'h1234_5678, 1'b1, 1);
    chk("flush_stb_held", n_stb,             32'd3);
    chk("flush_dav",      {31'd0, o_dav_ff},  32'd0);
    chk("flush_dabt",     {31'd0, o_dabt_ff}, 32'd0);
    load_test("post_flush", 1'b0, 1'b0, 1'b0, 1'b0, 32'h600, 32'hCAFE_BABE, 32'hCAFE_BABE);

    // Reset mid-BUSY drops the request; a late ack is ignored.
    issue_mem(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h700, 32'd0, 6'd8);
    tick();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    chk("rstb_stb",   {31'd0, o_data_stb},   32'd0);
    chk("rstb_stall", {31'd0, o_data_stall}, 32'd0);
    i_data_ack = 1'b1;
    tick();
    i_data_ack = 1'b0;
    chk("late_ack_dav",   {31'd0, o_dav_ff},     32'd0);
    chk("late_ack_stall", {31'd0, o_data_stall}, 32'd0);

    // Back-to-back LDR, ADD: the ADD is held during BUSY and appears one cycle later.
    issue_mem(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h800, 32'd0, 6'd10);
    drive_add(32'h99, 6'd11);
    busy(2, 32'h0000_ABCD, 1'b0, 0);
    total_dav = n_dav;
    chk("b2b_ldr_dav",  {31'd0, o_dav_ff},      32'd1);
    chk("b2b_ldr_load", {31'd0, o_mem_load_ff}, 32'd1);
    chk("b2b_ldr_data", o_mem_load_data_ff,     32'h0000_ABCD);
    if (o_dav_ff) total_dav++;
    tick();
    drive_nop();
    chk("b2b_add_dav",  {31'd0, o_dav_ff},      32'd1);
    chk("b2b_add_res",  o_alu_result_ff,        32'h99);
    chk("b2b_add_dst",  {26'd0, o_destination_index_ff}, 32'd11);
    chk("b2b_add_load", {31'd0, o_mem_load_ff}, 32'd0);
    if (o_dav_ff) total_dav++;
    tick();
    if (o_dav_ff) total_dav++;
    chk("b2b_dav_pulses", total_dav, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
